// File: rtl/req_arbiter_4.sv
// Four-requester arbiter: a fixed or round-robin priority encoder picks a winner in IDLE,
// and a two-state FSM holds the registered grant until release or hold-time expiry.
module req_arbiter_4 #(
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic          grant_valid_q, grant_valid_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  logic          win_valid;
  logic [1:0]    win_id;
  logic [1:0]    rr_idx;

  // Winner selection. In RR mode the scan runs from the farthest offset down to ptr so
  // the last overwrite is the requester closest to (and including) ptr.
  always_comb begin
    win_valid = |req;
    win_id    = 2'd0;
    rr_idx    = 2'd0;
    if (ROUND_ROBIN == 0) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i]) win_id = 2'(i);
      end
    end else begin
      for (int k = 3; k >= 0; k--) begin
        rr_idx = ptr_q + 2'(k);
        if (req[rr_idx]) win_id = rr_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d       = GRANT;
          grant_d       = 4'b0001 << win_id;
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
          ptr_d         = win_id + 2'd1;
        end
      end
      GRANT: begin
        // Release by the owner takes precedence over expiry, so timeout stays low then.
        if (done || !req[grant_id_q]) begin
          state_d       = IDLE;
          grant_d       = 4'b0000;
          grant_id_d    = 2'd0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d       = IDLE;
          grant_d       = 4'b0000;
          grant_id_d    = 2'd0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          timeout_d     = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = 4'b0000;
        grant_id_d    = 2'd0;
        grant_valid_d = 1'b0;
        hold_cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 4'b0000;
      grant_id_q    <= 2'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= 2'd0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Directed bench for req_arbiter_4: one fixed-priority and one round-robin instance,
// sharing clock and reset, each checked with immediate assertions.
module tb_req_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req_f, req_r;
  logic       done_f, done_r;
  logic [3:0] grant_f, grant_r;
  logic [1:0] grant_id_f, grant_id_r;
  logic       grant_valid_f, grant_valid_r;
  logic       timeout_f, timeout_r;

  int tests;
  int fails;

  req_arbiter_4 #(.ROUND_ROBIN(0), .MAX_HOLD(8)) dut_fx (
    .clk(clk), .rst(rst), .req(req_f), .done(done_f),
    .grant(grant_f), .grant_id(grant_id_f), .grant_valid(grant_valid_f), .timeout(timeout_f)
  );

  req_arbiter_4 #(.ROUND_ROBIN(1), .MAX_HOLD(8)) dut_rr (
    .clk(clk), .rst(rst), .req(req_r), .done(done_r),
    .grant(grant_r), .grant_id(grant_id_r), .grant_valid(grant_valid_r), .timeout(timeout_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_f(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic v, input logic to);
    logic [7:0] obs, exp;
    obs = {grant_f, grant_id_f, grant_valid_f, timeout_f};
    exp = {g, id, v, to};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s fixed: {grant,id,valid,timeout} got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [3:0] g, input logic [1:0] id,
                       input logic v, input logic to);
    logic [7:0] obs, exp;
    obs = {grant_r, grant_id_r, grant_valid_r, timeout_r};
    exp = {g, id, v, to};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s rr: {grant,id,valid,timeout} got %b want %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] rr_seq [5];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    req_f  = 4'b0000;
    req_r  = 4'b0000;
    done_f = 1'b0;
    done_r = 1'b0;

    // 1. Reset values, then idle clocks with no requests.
    #2;
    chk_f("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk_r("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_f("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);
      chk_r("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // 2. Fixed priority, all requesting: owner 3 every time, one bubble between.
    req_f = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_f("fx_grant_c1", 4'b1000, 2'd3, 1'b1, 1'b0);
      tick();
      chk_f("fx_grant_c2", 4'b1000, 2'd3, 1'b1, 1'b0);
      done_f = 1'b1;
      tick();
      done_f = 1'b0;
      chk_f("fx_bubble", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    req_f = 4'b0000;

    // 3. Round robin, all requesting: 0,1,2,3,0 with bubbles.
    req_r = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk_r("rr_grant_c1", 4'b0001 << rr_seq[n], rr_seq[n], 1'b1, 1'b0);
      tick();
      chk_r("rr_grant_c2", 4'b0001 << rr_seq[n], rr_seq[n], 1'b1, 1'b0);
      done_r = 1'b1;
      tick();
      done_r = 1'b0;
      chk_r("rr_bubble", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // 4. Hold expiry: 8 grant cycles, timeout bubble, regrant; then done on cycle 8.
    req_r = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk_r("hold_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    tick();
    chk_r("hold_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_r("hold_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk_r("hold_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    done_r = 1'b1;
    tick();
    done_r = 1'b0;
    chk_r("done_beats_expiry", 4'b0000, 2'd0, 1'b0, 1'b0);
    req_r = 4'b0000;
    tick();
    chk_r("idle_after_done", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 5. ptr=3 now: owner 1 wins; non-owner toggles ignored; drop req[1] with 1001 held.
    req_r = 4'b0010;
    tick();
    chk_r("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_r = 4'b1011;
    tick();
    chk_r("own1_toggle", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_r = 4'b1001;
    tick();
    chk_r("own1_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_r("rr_from_ptr2", 4'b1000, 2'd3, 1'b1, 1'b0);
    req_r = 4'b1111;
    tick();
    chk_r("own3_toggle_a", 4'b1000, 2'd3, 1'b1, 1'b0);
    req_r = 4'b1010;
    tick();
    chk_r("own3_toggle_b", 4'b1000, 2'd3, 1'b1, 1'b0);
    req_r = 4'b0000;
    tick();
    chk_r("own3_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // 6. Async reset mid-grant. With req=1010, ptr=0 picks 1; a stale ptr=2 would pick 3.
    req_r = 4'b1010;
    tick();
    chk_r("pre_reset_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_r("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    chk_r("post_reset_ptr0", 4'b0010, 2'd1, 1'b1, 1'b0);
    chk_f("fx_idle_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
